// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// The winner is reported one-hot and as a 3-bit binary index.
// A grant is held until the requester drops its bit or MAX_HOLD cycles elapse.
// Fairness comes from a priority pointer. The pointer moves past the released
// index on every release or timeout, and never on a grant.
module rr_arbiter_8to3 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Last hold-count value before a forced release (MAX_HOLD is 1..255).
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       to_q, to_d;

  logic [2:0] win;
  logic [2:0] cand;
  logic       found;
  logic       any_req;
  logic       owner_drop;
  logic       hold_expired;

  assign any_req      = |req_i;
  assign owner_drop   = ~req_i[idx_q];
  assign hold_expired = (cnt_q == HOLD_LAST);

  // Rotating priority search: first set request at or above ptr, wrapping at 8.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant from IDLE on any request; leave BUSY on drop or hold limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (owner_drop || hold_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: grant capture, hold counting, release and pointer update.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    vld_d = vld_q;
    to_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = 8'b1 << win;
          idx_d = win;
          vld_d = 1'b1;
          cnt_d = '0;
        end else begin
          gnt_d = '0;
          idx_d = '0;
          vld_d = 1'b0;
        end
      end
      BUSY: begin
        if (owner_drop || hold_expired) begin
          // A still-requested grant at the hold limit is a forced release.
          gnt_d = '0;
          idx_d = '0;
          vld_d = 1'b0;
          ptr_d = idx_q + 3'd1;
          to_d  = ~owner_drop;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
        vld_d = 1'b0;
      end
    endcase
  end

  // Datapath registers: outputs are registered so they clear asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      to_q  <= to_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = vld_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Bench for rr_arbiter_8to3. A reference model pushes the expected outputs
// onto a queue each cycle. Each scenario task pops them and compares them
// with the sampled DUT outputs. It also checks the scenario's
// grant-order, duration and timeout properties against fixed constants.
module tb_rr_arbiter_8to3;
  localparam int MH = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req   = '0;

  logic [7:0] gnt, gnt1;
  logic [2:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1, timeout, timeout1;

  rr_arbiter_8to3 #(.MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .gnt_valid_o(gnt_valid), .timeout_o(timeout)
  );

  rr_arbiter_8to3 #(.MAX_HOLD(1)) dut_h1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .gnt_o(gnt1), .gnt_idx_o(gnt_idx1), .gnt_valid_o(gnt_valid1), .timeout_o(timeout1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  out_t obs1_q[$];
  int   tests = 0;
  int   fails = 0;

  int   m_g   = -1;
  int   m_cnt = 0;
  int   m_ptr = 0;
  logic m_to  = 1'b0;

  function automatic out_t pack_out(input logic [7:0] g, input logic [2:0] i,
                                    input logic v, input logic t);
    out_t o;
    o.gnt = g;
    o.idx = i;
    o.vld = v;
    o.to  = t;
    return o;
  endfunction

  task automatic model_reset();
    m_g   = -1;
    m_cnt = 0;
    m_ptr = 0;
    m_to  = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    if (m_g < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (m_g < 0 && r[(m_ptr + k) % 8]) begin
          m_g   = (m_ptr + k) % 8;
          m_cnt = 0;
        end
      end
    end else if (!r[m_g]) begin
      m_ptr = (m_g + 1) % 8;
      m_g   = -1;
      m_to  = 1'b0;
    end else if (m_cnt == MH - 1) begin
      m_ptr = (m_g + 1) % 8;
      m_g   = -1;
      m_to  = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
      m_to  = 1'b0;
    end
  endtask

  function automatic out_t model_out();
    if (m_g < 0) return pack_out(8'h00, 3'd0, 1'b0, m_to);
    return pack_out(8'(1 << m_g), 3'(m_g), 1'b1, m_to);
  endfunction

  // Drive one cycle of requests, record the expected and the observed outputs.
  task automatic step(input logic [7:0] r);
    req = r;
    model_step(r);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(pack_out(gnt, gnt_idx, gnt_valid, timeout));
    obs1_q.push_back(pack_out(gnt1, gnt_idx1, gnt_valid1, timeout1));
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    obs1_q.delete();
  endtask

  task automatic test_reset();
    #1;
    req   = 8'hFF;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'b0) begin
      fails++;
      $display("FAIL reset_async: got %b want %b", {gnt, gnt_idx, gnt_valid, timeout}, 13'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({gnt, gnt_idx, gnt_valid, timeout, gnt1, gnt_idx1, gnt_valid1, timeout1} !== 26'b0) begin
      fails++;
      $display("FAIL reset_held: got %b want 0", {gnt, gnt_idx, gnt_valid, timeout, gnt1, gnt_idx1, gnt_valid1, timeout1});
    end
    rst_n = 1'b1;
    req   = '0;
    model_reset();
  endtask

  task automatic test_single();
    out_t e;
    do_reset();
    step(8'h08);
    step(8'h08);
    step(8'h00);
    step(8'hFF);
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL single cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    tests++;
    if (obs_q[0] !== pack_out(8'h08, 3'd3, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL single_grant: got %b want %b", obs_q[0], pack_out(8'h08, 3'd3, 1'b1, 1'b0));
    end
    tests++;
    if (obs_q[2] !== 13'b0) begin
      fails++;
      $display("FAIL single_release: got %b want 0", obs_q[2]);
    end
    tests++;
    if (obs_q[3].idx !== 3'd4 || obs_q[3].vld !== 1'b1) begin
      fails++;
      $display("FAIL single_ptr: got idx=%0d vld=%b want idx=4 vld=1", obs_q[3].idx, obs_q[3].vld);
    end
  endtask

  task automatic test_rotation();
    out_t e;
    int   g;
    int   exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    do_reset();
    for (int n = 0; n < 9; n++) begin
      step(8'hFF);
      g = m_g;
      step(8'hFF);
      step(8'hFF & ~(8'(1 << g)));
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL rotation cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    for (int n = 0; n < 9; n++) begin
      tests++;
      if (obs_q[3*n].idx !== 3'(exp_order[n]) || obs_q[3*n].vld !== 1'b1 ||
          obs_q[3*n+2].vld !== 1'b0) begin
        fails++;
        $display("FAIL rotation_order n%0d: got idx=%0d vld=%b dead_vld=%b want idx=%0d vld=1 dead_vld=0",
                 n, obs_q[3*n].idx, obs_q[3*n].vld, obs_q[3*n+2].vld, exp_order[n]);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    out_t e;
    int   g;
    int   exp_order[6] = '{1, 2, 3, 5, 7, 1};
    do_reset();
    for (int n = 0; n < 6; n++) begin
      step(8'hAE);
      g = m_g;
      step(8'hAE);
      step(8'hAE & ~(8'(1 << g)));
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL sparse cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    for (int n = 0; n < 6; n++) begin
      tests++;
      if (obs_q[3*n].idx !== 3'(exp_order[n]) ||
          obs_q[3*n].gnt !== 8'(1 << exp_order[n])) begin
        fails++;
        $display("FAIL sparse_order n%0d: got idx=%0d gnt=%b want idx=%0d", n,
                 obs_q[3*n].idx, obs_q[3*n].gnt, exp_order[n]);
      end
    end
  endtask

  task automatic test_timeout();
    out_t e;
    int   run;
    int   pulses;
    do_reset();
    repeat (40) step(8'h20);
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL timeout cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    run = 0;
    while (run < obs_q.size() && obs_q[run].vld === 1'b1) run++;
    tests++;
    if (run != 16) begin
      fails++;
      $display("FAIL timeout_len: got %0d cycles want 16", run);
    end
    pulses = 0;
    for (int i = 0; i < 33; i++) if (obs_q[i].to === 1'b1) pulses++;
    tests++;
    if (pulses != 1 || obs_q[16] !== pack_out(8'h00, 3'd0, 1'b0, 1'b1)) begin
      fails++;
      $display("FAIL timeout_pulse: got pulses=%0d cyc16=%b want pulses=1 cyc16=%b",
               pulses, obs_q[16], pack_out(8'h00, 3'd0, 1'b0, 1'b1));
    end
    tests++;
    if (obs_q[17] !== pack_out(8'h20, 3'd5, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL timeout_regrant: got %b want %b", obs_q[17], pack_out(8'h20, 3'd5, 1'b1, 1'b0));
    end
  endtask

  task automatic test_timeout_fairness();
    out_t e;
    int   first_to;
    do_reset();
    step(8'h20);
    repeat (24) step(8'h21);
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL fairness cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    first_to = -1;
    for (int i = 0; i < obs_q.size(); i++) if (first_to < 0 && obs_q[i].to === 1'b1) first_to = i;
    tests++;
    if (first_to != 16 || obs_q[0].idx !== 3'd5) begin
      fails++;
      $display("FAIL fairness_first: got timeout_at=%0d first_idx=%0d want 16 and 5", first_to, obs_q[0].idx);
    end
    tests++;
    if (obs_q[17].idx !== 3'd0 || obs_q[17].vld !== 1'b1) begin
      fails++;
      $display("FAIL fairness_next: got idx=%0d vld=%b want idx=0 vld=1", obs_q[17].idx, obs_q[17].vld);
    end
  endtask

  task automatic test_reset_mid_grant();
    out_t e;
    do_reset();
    step(8'h40);
    step(8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'b0) begin
      fails++;
      $display("FAIL reset_mid: got %b want 0", {gnt, gnt_idx, gnt_valid, timeout});
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    step(8'h41);
    step(8'h41);
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    tests++;
    if (obs_q[0].idx !== 3'd6 || obs_q[2] !== pack_out(8'h01, 3'd0, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL reset_mid_regrant: got before=%0d after=%b want 6 and %b",
               obs_q[0].idx, obs_q[2], pack_out(8'h01, 3'd0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_max_hold_one();
    out_t e;
    out_t want;
    do_reset();
    repeat (6) step(8'h04);
    for (int i = 0; i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q[i] !== e) begin
        fails++;
        $display("FAIL hold1_main cyc%0d: got %b want %b", i, obs_q[i], e);
      end
    end
    for (int i = 0; i < obs1_q.size(); i++) begin
      want = (i % 2 == 0) ? pack_out(8'h04, 3'd2, 1'b1, 1'b0) : pack_out(8'h00, 3'd0, 1'b0, 1'b1);
      tests++;
      if (obs1_q[i] !== want) begin
        fails++;
        $display("FAIL hold1 cyc%0d: got %b want %b", i, obs1_q[i], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_sparse_wrap();
    test_timeout();
    test_timeout_fairness();
    test_reset_mid_grant();
    test_max_hold_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
